// File: rtl/binary_to_gray_counter.sv
// rtl/binary_to_gray_counter.sv - registered up/down binary counter with flopped Gray output
//
// Purpose:
//   Up/down binary counter whose count is also presented in Gray code. The
//   Gray value is computed from the next binary state and registered, so the
//   gray output comes straight from a flop. This makes it usable as an
//   async-FIFO pointer that crosses clock domains.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous active-high reset
//   en         in   1      count enable, one step per cycle while high
//   up         in   1      direction: 1 = increment, 0 = decrement
//   load       in   1      synchronous load of load_bin, takes priority over en
//   load_bin   in   WIDTH  binary value to load
//   binary     out  WIDTH  registered binary count
//   gray       out  WIDTH  registered Gray code of binary
//   gray_next  out  WIDTH  combinational Gray value for the next edge
//                          (same-domain compares only, never cross domains)
//   wrap       out  1      registered one-cycle pulse on a count wrap

module binary_to_gray_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] binary,
  output logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] gray_next,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_binary;
  logic [WIDTH-1:0] r_gray;
  logic             r_wrap;

  logic [WIDTH-1:0] w_bin_next;
  logic [WIDTH-1:0] w_gray_next;
  logic             w_wrap_next;

  // Load wins over en; up and load_bin are only looked at when they matter,
  // so X on them while idle cannot reach the state.
  always_comb begin
    w_bin_next  = r_binary;
    w_wrap_next = 1'b0;
    if (load) begin
      w_bin_next = load_bin;
    end else if (en) begin
      if (up) begin
        w_bin_next  = r_binary + ONE;
        w_wrap_next = &r_binary;
      end else begin
        w_bin_next  = r_binary - ONE;
        w_wrap_next = ~|r_binary;
      end
    end
  end

  // Gray is derived from the next binary state so the flopped gray output
  // needs no logic after the register.
  assign w_gray_next = w_bin_next ^ (w_bin_next >> 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_binary <= '0;
      r_gray   <= '0;
      r_wrap   <= 1'b0;
    end else begin
      r_binary <= w_bin_next;
      r_gray   <= w_gray_next;
      r_wrap   <= w_wrap_next;
    end
  end

  assign binary    = r_binary;
  assign gray      = r_gray;
  assign wrap      = r_wrap;
  assign gray_next = w_gray_next;

endmodule
